// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive path: FSM states, byte type,
// default timing and the LSB-first shift helper.
package uart_rx_fifo_pkg;

  localparam int unsigned FRAME_W        = 8;
  localparam int unsigned DEF_BAUD_DIV   = 434;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef logic [FRAME_W-1:0] rx_byte_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Serial data arrives LSB first, so new bits enter at the MSB end.
  function automatic rx_byte_t shift_in(rx_byte_t sr, logic bit_in);
    return {bit_in, sr[FRAME_W-1:1]};
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Serial line plus CPU-side receive register signals of the UART RX front end.
interface uart_rx_fifo_if;
  import uart_rx_fifo_pkg::*;

  logic     ser_rxd;
  logic     rd_en;
  logic     err_clr;
  rx_byte_t rx_data;
  logic     rx_valid;
  logic     frame_err;
  logic     overrun;

  modport master (
    output ser_rxd, rd_en, err_clr,
    input  rx_data, rx_valid, frame_err, overrun
  );

  modport slave (
    input  ser_rxd, rd_en, err_clr,
    output rx_data, rx_valid, frame_err, overrun
  );

endinterface

// File: rtl/uart_rx_fifo_rx_fifo.sv
// Synchronous show-ahead byte FIFO; head entry is visible on rd_data without a read.
module uart_rx_fifo_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  rx_byte_t wr_data,
  output logic     full,
  output logic     empty,
  output rx_byte_t rd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rx_byte_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_pop_c;
  logic               do_push_c;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign rd_data   = mem[rd_ptr];
  assign do_pop_c  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push_c = push && (!full || do_pop_c);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: input synchroniser, deframer FSM, sticky error flags and a
// show-ahead receive FIFO for the CPU register interface.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = DEF_BAUD_DIV,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
  localparam int unsigned HALF_DIV = BAUD_DIV / 2;

  rx_state_e        state;
  logic             rxd_m;
  logic             rxd_s;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  rx_byte_t         shift;
  logic             frame_err;
  logic             overrun;

  logic             baud_last_c;
  logic             push_c;
  logic             stop_bad_c;
  logic             pop_c;
  logic             fifo_full;
  logic             fifo_empty;
  rx_byte_t         fifo_head;

  assign baud_last_c = (baud_cnt == CNT_W'(BAUD_DIV - 1));
  assign push_c      = (state == ST_STOP) && baud_last_c && rxd_s;
  assign stop_bad_c  = (state == ST_STOP) && baud_last_c && !rxd_s;
  assign pop_c       = bus.rd_en && !fifo_empty;

  // Synchroniser, deframer and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rxd_m <= bus.ser_rxd;
      rxd_s <= rxd_m;

      case (state)
        ST_IDLE: begin
          if (!rxd_s) begin
            state    <= ST_START;
            baud_cnt <= '0;
          end
        end
        ST_START: begin
          if (baud_cnt == CNT_W'(HALF_DIV - 1)) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_last_c) begin
            baud_cnt <= '0;
            shift    <= shift_in(shift, rxd_s);
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (baud_last_c) begin
            baud_cnt <= '0;
            state    <= rxd_s ? ST_IDLE : ST_BREAK;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        ST_BREAK: begin
          if (rxd_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (stop_bad_c) begin
        frame_err <= 1'b1;
      end else if (bus.err_clr) begin
        frame_err <= 1'b0;
      end

      if (push_c && fifo_full && !pop_c) begin
        overrun <= 1'b1;
      end else if (bus.err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  uart_rx_fifo_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .wr_data (shift),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .rd_data (fifo_head)
  );

  assign bus.rx_data   = fifo_head;
  assign bus.rx_valid  = !fifo_empty;
  assign bus.frame_err = frame_err;
  assign bus.overrun   = overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial characters driven bit by bit, checked against a
// byte-queue model of the receive FIFO and the two sticky flags.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int unsigned BAUD      = 16;
  localparam int unsigned DEPTH     = 4;
  localparam int          FRAME_CYC = 10 * BAUD;
  localparam int          LAT       = 2 + BAUD / 2 + 9 * BAUD + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mq[$];
  logic       m_fe;
  logic       m_ov;
  logic [7:0] burst [5] = '{8'h55, 8'h0F, 8'hF0, 8'h81, 8'h3C};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, 8'(bus.rx_valid), 8'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, ".data"}, bus.rx_data, mq[0]);
    chk({tag, ".frame_err"}, 8'(bus.frame_err), 8'(m_fe));
    chk({tag, ".overrun"}, 8'(bus.overrun), 8'(m_ov));
  endtask

  // Drives one 8N1 character (or its first ncyc cycles); optional rd_en/err_clr on the stop-sample cycle.
  task automatic send_char(input logic [7:0] d, input logic stop, input bit pop_at_stop,
                           input bit clr_at_stop, input bit lat_chk, input int ncyc);
    logic set_fe;
    logic set_ov;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (lat_chk && i == LAT - 1) chk("latency.before", 8'(bus.rx_valid), 8'd0);
      if (lat_chk && i == LAT)     chk("latency.at", 8'(bus.rx_valid), 8'd1);
      bus.rd_en   = pop_at_stop && (i == LAT - 1);
      bus.err_clr = clr_at_stop && (i == LAT - 1);
      if (i < int'(BAUD))          bus.ser_rxd = 1'b0;
      else if (i < int'(9 * BAUD)) bus.ser_rxd = d[3'((i / int'(BAUD)) - 1)];
      else                         bus.ser_rxd = stop;
    end
    if (ncyc == FRAME_CYC) begin
      set_fe = !stop;
      set_ov = 1'b0;
      if (pop_at_stop && mq.size() != 0) void'(mq.pop_front());
      if (stop) begin
        if (mq.size() < int'(DEPTH)) mq.push_back(d);
        else set_ov = 1'b1;
      end
      m_fe = set_fe ? 1'b1 : (clr_at_stop ? 1'b0 : m_fe);
      m_ov = set_ov ? 1'b1 : (clr_at_stop ? 1'b0 : m_ov);
    end
  endtask

  task automatic read_check(input string tag);
    if (mq.size() == 0) begin
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      check_state({tag, ".empty"});
    end else begin
      chk({tag, ".valid"}, 8'(bus.rx_valid), 8'd1);
      chk({tag, ".data"}, bus.rx_data, mq[0]);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      void'(mq.pop_front());
    end
  endtask

  task automatic err_pulse();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.ser_rxd = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    rst         = 1'b0;
    bus.ser_rxd = 1'b1;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    m_fe        = 1'b0;
    m_ov        = 1'b0;
    repeat (3) tick();
    check_state("reset");
    chk("reset.rx_data", bus.rx_data, 8'h00);
    rst = 1'b1;
    idle(4);

    // Single character with exact latency.
    send_char(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, FRAME_CYC);
    check_state("a5");
    read_check("a5.rd");
    check_state("a5.after");

    // Five back-to-back characters overflow a four-entry FIFO.
    for (int k = 0; k < 5; k++) send_char(burst[k], 1'b1, 1'b0, 1'b0, 1'b0, FRAME_CYC);
    check_state("burst");
    chk("burst.overrun_set", 8'(bus.overrun), 8'd1);
    repeat (4) read_check("burst.rd");
    check_state("burst.drained");
    err_pulse();
    check_state("burst.cleared");

    // Full FIFO with a pop on the stop-sample cycle accepts the fifth byte.
    for (int k = 0; k < 4; k++) send_char(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, 1'b0, FRAME_CYC);
    send_char(8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0, 1'b0, FRAME_CYC);
    check_state("fullpop");
    repeat (4) read_check("fullpop.rd");
    check_state("fullpop.drained");

    // Bad stop bit then a long break: one frame error only.
    send_char(8'h33, 1'b0, 1'b0, 1'b0, 1'b0, FRAME_CYC);
    check_state("ferr");
    repeat (20 * BAUD) tick();
    err_pulse();
    repeat (20 * BAUD) tick();
    check_state("break.hold");
    idle(2 * BAUD);
    send_char(8'h66, 1'b1, 1'b0, 1'b0, 1'b0, FRAME_CYC);
    check_state("after_break");
    read_check("after_break.rd");
    check_state("after_break.empty");

    // Flag set and err_clr on the same cycle: set wins.
    send_char(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1, 1'b0, FRAME_CYC);
    check_state("set_wins");
    idle(2 * BAUD);
    err_pulse();
    check_state("set_wins.cleared");

    // Short low glitch is rejected at mid start bit.
    bus.ser_rxd = 1'b0;
    repeat (5) tick();
    idle(3 * BAUD);
    check_state("glitch");
    read_check("empty_rd");

    // Random characters, stop bits, reads and stop-cycle pops.
    for (int k = 0; k < 12; k++) begin
      logic good;
      good = ($urandom_range(0, 7) != 0);
      send_char(8'($urandom_range(0, 255)), good, 1'($urandom_range(0, 1)), 1'b0, 1'b0, FRAME_CYC);
      if (!good) idle(2 * BAUD);
      check_state("rand");
      repeat ($urandom_range(0, 2)) read_check("rand.rd");
    end
    err_pulse();
    while (mq.size() != 0) read_check("rand.drain");
    check_state("rand.done");

    // Reset mid character with a byte buffered.
    send_char(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, FRAME_CYC);
    check_state("pre_rst");
    send_char(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 5 * BAUD);
    rst         = 1'b0;
    bus.ser_rxd = 1'b1;
    tick();
    rst = 1'b1;
    mq.delete();
    m_fe = 1'b0;
    m_ov = 1'b0;
    check_state("mid_rst");
    chk("mid_rst.rx_data", bus.rx_data, 8'h00);
    idle(2 * BAUD);
    send_char(8'h9C, 1'b1, 1'b0, 1'b0, 1'b0, FRAME_CYC);
    check_state("post_rst");
    read_check("post_rst.rd");
    check_state("post_rst.empty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
